// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, angle helpers and FSM states for the CORDIC blocks.
package cordic_pkg;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int ITER = 1 << ADDR_WIDTH_DEF;
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
    function automatic int iter_count(input int aw);
        return 1 << aw;
    endfunction
    function automatic int ANG_PI_2(input int dw);
        return 1 << (dw - 2);
    endfunction
    function automatic int ANG_PI(input int dw);
        return 1 << (dw - 1);
    endfunction
endpackage

// File: rtl/cordic_vector_atan_rom.sv
// atan_rom: combinational atan(2^-i) table in binary-angle units (pi = 2^(DATA_WIDTH-1)).
module atan_rom #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);
    localparam logic [15:0] TBL [16] = '{16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326,
                                         16'd163, 16'd81, 16'd41, 16'd20, 16'd10, 16'd5,
                                         16'd3, 16'd1, 16'd1, 16'd0};
    logic [31:0] a;
    logic [31:0] s;
    assign a = 32'(addr);
    // Table is stored at 16-bit angle precision and rescaled to the configured width
    assign s = a < 32'd16 ? {TBL[a[3:0]], 16'b0} >> (32 - DATA_WIDTH) : '0;
    assign q = s[DATA_WIDTH-1:0];
endmodule

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC returning atan2 phase and K-scaled magnitude.
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    output logic                         done,
    output logic [DATA_WIDTH+1:0]        mag,
    output logic signed [DATA_WIDTH-1:0] phase
);
    localparam int W = DATA_WIDTH + 2;
    state_t state;
    logic [ADDR_WIDTH-1:0] iter;
    logic signed [W-1:0] x, y, xe, ye, x0, y0, xn, yn;
    logic [DATA_WIDTH-1:0] z, z0, zn, a;
    logic zero_flag, neg;
    atan_rom #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rom (.addr(iter), .q(a));
    assign xe = {{2{x_in[DATA_WIDTH-1]}}, x_in};
    assign ye = {{2{y_in[DATA_WIDTH-1]}}, y_in};
    // Left half-plane is folded into the right half by a +/-90 degree pre-rotation
    always_comb begin
        x0 = !xe[W-1] ? xe : !ye[W-1] ? ye : -ye;
        y0 = !xe[W-1] ? ye : !ye[W-1] ? -xe : xe;
        z0 = !xe[W-1] ? '0 : !ye[W-1] ? DATA_WIDTH'(ANG_PI_2(DATA_WIDTH)) : DATA_WIDTH'(-ANG_PI_2(DATA_WIDTH));
    end
    assign neg = y[W-1];
    assign xn = neg ? x - (y >>> iter) : x + (y >>> iter);
    assign yn = neg ? y + (x >>> iter) : y - (x >>> iter);
    assign zn = neg ? z - a : z + a;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            iter      <= '0;
            done      <= 1'b0;
            mag       <= '0;
            phase     <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            zero_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    x         <= x0;
                    y         <= y0;
                    z         <= z0;
                    iter      <= '0;
                    zero_flag <= x_in == '0 && y_in == '0;
                    state     <= ROT;
                end
                ROT: begin
                    x    <= xn;
                    y    <= yn;
                    z    <= zn;
                    iter <= iter + 1'b1;
                    if (&iter) begin
                        mag   <= xn;
                        phase <= zero_flag ? '0 : zn;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cordic_vector.md
# cordic_vector

Iterative CORDIC in vectoring mode. It takes a Cartesian vector (x_in, y_in) and returns its angle (atan2) and its gain-scaled magnitude. It is the inverse of the rotation-mode `cordic`, which maps an angle to cos/sin. It uses the same binary-angle format and the same en/done start–finish handshake, so a phase out of this block can be fed straight back into `cordic`.

## Interface
- DATA_WIDTH, 16, width of x_in, y_in and phase (two's complement)
- ADDR_WIDTH, 4, atan ROM address width; iteration count N = 2^ADDR_WIDTH
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock, asynchronous, active-low (asserted when 0)
- en  in  1  start request, sampled only in IDLE
- x_in  in  DATA_WIDTH  signed x component
- y_in  in  DATA_WIDTH  signed y component
- done  out  1  one-cycle pulse: mag/phase updated this cycle
- mag  out  DATA_WIDTH+2  unsigned, K·sqrt(x²+y²), where K = 1.64676 for N=16 (no gain compensation)
- phase  out  DATA_WIDTH  signed binary angle: 2^(DATA_WIDTH-1) represents π, so one LSB is π/2^(DATA_WIDTH-1)

## Operation
- States: IDLE, ROT, DONE.
- IDLE, en=1 at a clock edge: capture the inputs sign-extended to W = DATA_WIDTH+2 bits. Apply quadrant pre-rotation, set iter=0, go to ROT.
  - x ≥ 0: x'=x, y'=y, z=0.
  - x < 0, y ≥ 0: x'=y, y'=−x, z=+π/2 (2^(DATA_WIDTH-2)).
  - x < 0, y < 0: x'=−y, y'=x, z=−π/2.
  - Also register zero_flag = (x_in==0 && y_in==0).
- ROT, one micro-rotation per cycle, with i=iter and a=atan_rom[i]:
  - y ≥ 0: x += y>>>i, y −= x>>>i, z += a.
  - y < 0: x −= y>>>i, y += x>>>i, z −= a.
  - Both updates use the pre-update x and y. Shifts are arithmetic.
  - After i = N−1: register mag = x[W-1:0] (always ≥ 0 after pre-rotation), phase = zero_flag ? 0 : z. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- z accumulator is DATA_WIDTH bits and wraps modulo 2^DATA_WIDTH, so +π ≡ −π. Results at ±π may read as −2^(DATA_WIDTH-1) or 2^(DATA_WIDTH-1)−1.
- en is ignored in ROT and DONE; no queuing. x_in and y_in need only be valid on the sampling edge.
- mag and phase hold their last result until the next DONE.
- ROM contents: q[i] = round(atan(2^-i)·2^(DATA_WIDTH-1)/π). For DATA_WIDTH=16: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, iter=0, done=0, mag=0, phase=0, internal x/y/z=0.
- Reset mid-ROT aborts the operation. No done pulse, outputs go to 0.
- Latency: en sampled at edge k. Iterations occur at edges k+1..k+N. done is high in the cycle following edge k+N, together with the new mag/phase.
- Throughput: one result per N+2 cycles. The earliest next start is the edge ending the cycle after DONE, i.e. en sampled in IDLE.
- en held continuously high restarts on every IDLE visit.

## Structure
- `cordic_pkg` holds shared constants and helpers for both CORDIC blocks:
  - ITER = 2^ADDR_WIDTH
  - angle helpers ANG_PI_2(dw) = 2^(dw-2) and ANG_PI(dw)
  - state enum {IDLE, ROT, DONE}
- Sub-module `atan_rom`: combinational, addr ADDR_WIDTH → q DATA_WIDTH. It has the same port shape as the existing `rom`, so `rom` is reused if its contents match the table above.
- Core FSM and datapath live in `cordic_vector`.

## Test plan
- x=16384, y=0 → phase 0 ±2 LSB, mag 26981 ±4; done exactly 16 edges after en sampled.
- x=0, y=16384 → phase 16384 ±2, mag 26981 ±4.
- x=−16384, y=−16384 → phase −24576 ±2, mag 38157 ±6 (pre-rotation path −π/2).
- x=−32768, y=0 → phase in {−32768, 32767} (±2 wrap), mag 53963 ±6; no overflow in the W-bit datapath.
- x=0, y=0 → mag 0, phase 0, done on schedule.
- Start with en held high. Assert rst=0 at iter 7 → no done, outputs 0. Release rst, re-issue x=16384, y=0 → correct result. Pulse en during ROT → ignored, only one done.
